// File: rtl/bcd_count_ctrl.sv
// Run controller for the two-digit BCD counter: start/stop, lap counting to a
// target, and terminal-count reconfiguration deferred to the next wrap.
module bcd_count_ctrl (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [6:0] cfg_max,
  input  logic [3:0] lap_target,
  input  logic [6:0] count_in,
  output logic       run,
  output logic [6:0] max_count,
  output logic       wrap,
  output logic [3:0] lap_cnt,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  logic [6:0] pending_max;

  logic cfg_fire;
  logic cfg_legal;
  logic term;
  logic lap_hit;
  logic finish;

  // term mirrors the counter's own wrap decision, so it uses the same registered run/max_count
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_max <= 7'd99);
  assign term      = run && (count_in >= max_count);
  assign lap_hit   = (lap_target != 4'd0) && ((lap_cnt + 4'd1) == lap_target);
  assign finish    = term && lap_hit;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state       <= IDLE;
      run         <= 1'b0;
      max_count   <= 7'd99;
      pending_max <= 7'd0;
      cfg_ready   <= 1'b1;
      wrap        <= 1'b0;
      lap_cnt     <= 4'd0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      wrap    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;

      // Lap bookkeeping happens on every wrap, even one coinciding with stop
      if (term) begin
        wrap <= 1'b1;
        if (lap_hit) begin
          done    <= 1'b1;
          lap_cnt <= 4'd0;
        end else begin
          lap_cnt <= lap_cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          if (cfg_fire) begin
            if (cfg_legal) max_count <= cfg_max;
            else           cfg_err   <= 1'b1;
          end
          if (start && !stop) begin
            state   <= RUN;
            run     <= 1'b1;
            lap_cnt <= 4'd0;
          end
        end

        RUN: begin
          if (stop || finish) begin
            state <= IDLE;
            run   <= 1'b0;
            // Once idle nothing is pending, so a config landing on the done edge applies directly
            if (!stop && cfg_fire) begin
              if (cfg_legal) max_count <= cfg_max;
              else           cfg_err   <= 1'b1;
            end
          end else if (cfg_fire) begin
            if (cfg_legal) begin
              pending_max <= cfg_max;
              state       <= DRAIN;
              cfg_ready   <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        DRAIN: begin
          if (stop) begin
            state     <= IDLE;
            run       <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b1;
          end else if (term) begin
            max_count <= pending_max;
            cfg_ready <= 1'b1;
            state     <= finish ? IDLE : RUN;
            run       <= !finish;
          end
        end

        default: begin
          state     <= IDLE;
          run       <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Run controller for the programmable two-digit BCD counter. It drives the counter's `run` and `max_count` inputs and watches its binary count. It starts, stops and terminates counting after a programmed number of wraps (laps). It also reconfigures the terminal count safely while counting, by deferring each change to the next wrap boundary. It sits between the system control logic and the counter/BCD-converter pair.

## Interface
- No parameters. All widths are fixed: 7-bit count, 4-bit lap count.
- `CLK`  in  1  rising-edge clock shared with the counter
- `rst_n`  in  1  synchronous reset, active-low
- `start`  in  1  level; begin counting from IDLE
- `stop`  in  1  level; halt counting and return to IDLE
- `cfg_valid`  in  1  new terminal count offered
- `cfg_ready`  out  1  controller can accept `cfg_max`
- `cfg_max`  in  7  requested terminal count, legal range 0..99
- `lap_target`  in  4  wraps until done; 0 means free-run
- `count_in`  in  7  counter's current binary count
- `run`  out  1  counter enable, registered
- `max_count`  out  7  terminal count driven to the counter, registered
- `wrap`  out  1  one-cycle pulse after each counter wrap
- `lap_cnt`  out  4  wraps completed in the current run
- `done`  out  1  one-cycle pulse when `lap_target` is reached
- `cfg_err`  out  1  one-cycle pulse when a configuration is rejected or discarded

## Operation
- **Counter model.** On each `CLK` edge with `run`=1, the counter loads 0 if `count_in` >= `max_count`; otherwise it loads `count_in`+1. With `run`=0 the counter holds its value.
- **Terminal event (term).** An edge where `run`=1 and `count_in` >= `max_count`.
- **States:**
  - IDLE: `run`=0, `cfg_ready`=1.
  - RUN: `run`=1, `cfg_ready`=1.
  - DRAIN: `run`=1, a configuration is pending, `cfg_ready`=0.
- **IDLE transitions:**
  - `start`=1 and `stop`=0 → RUN. Clears `lap_cnt`.
  - An accepted legal config updates `max_count` at the same edge.
- **RUN transitions:**
  - An accepted legal config is stored in a pending register → DRAIN.
  - `start` is ignored.
- **DRAIN transitions:**
  - At term: `max_count` <= pending value, → RUN. Old and new values switch at the same edge the counter wraps to 0.
- **Stop.** `stop`=1 in RUN or DRAIN → IDLE at the next edge. A pending config is discarded and `cfg_err` pulses. `stop` takes priority over `start` and over a config in the same cycle.
- **Config handshake.** A transfer occurs on an edge where `cfg_valid` & `cfg_ready` are both 1. If `cfg_max` > 99, the transfer still completes, `cfg_err` pulses and nothing changes.
- **Lap counting.** At each term:
  - `wrap` pulses.
  - `lap_cnt` increments, wrapping 15→0.
  - If `lap_target`≠0 and `lap_cnt`+1 == `lap_target`: `done` pulses, `lap_cnt` <= 0, state → IDLE. The counter is left at 0.
- **Term coinciding with stop.** The wrap, lap and done updates still occur, because the counter did wrap. The resulting state is IDLE.
- **`max_count` = 0.** Legal. Every running edge is a term.

## Timing
- **Reset values:** state IDLE, `run`=0, `max_count`=99, `cfg_ready`=1, `wrap`=0, `lap_cnt`=0, `done`=0, `cfg_err`=0.
- Reset mid-run drops `run` at the same edge. Any pending config is lost without `cfg_err`.
- **Start latency:** `start` sampled at edge N → `run`=1 from edge N. The counter's first increment is at edge N+1.
- **Stop latency:** `stop` sampled at edge N → `run`=0 from edge N. An increment at edge N itself still occurs.
- **Term at edge N:**
  - `wrap`, `lap_cnt` and `done` are valid after edge N, together with `count_in`=0.
  - The `max_count` swap from DRAIN is visible after edge N.
- **Config in IDLE:** `max_count` updates at the transfer edge.
- **Config in RUN:** `cfg_ready` falls after the transfer edge and rises again after the term edge that applies the value.
- **Pulses:** `cfg_err`, `wrap` and `done` are exactly one cycle wide.

## Test plan
- **Basic lap run:** reset, counter at 0, `max_count` 99, `lap_target`=2, `start` pulse → `run` high; `wrap` after 100 and 200 counting edges; `done` with the second `wrap`; `run`=0, `count_in`=0, `lap_cnt`=0.
- **Deferred reconfig:** running with `max_count`=9 at count 4, offer `cfg_max`=25 → accepted; `cfg_ready` low; `max_count` stays 9 until wrap 9→0; then 25; next `wrap` after 26 more edges.
- **Illegal config:** `cfg_max`=100 offered in IDLE and in RUN → handshake completes, `cfg_err` one cycle, `max_count` unchanged, state unchanged.
- **Stop during DRAIN:** pending config, assert `stop` → `run`=0 next edge, `cfg_err` pulse, `max_count` keeps its old value, `cfg_ready`=1.
- **Stop at wrap:** `stop` on the term edge with `max_count`=0 and `lap_target`=0 → `wrap` pulses, `lap_cnt`=1, IDLE. `start`&`stop` together → stays IDLE.
- **Free-run lap wrap:** `lap_target`=0, `max_count`=0 → `wrap` every cycle; `lap_cnt` 15→0; never `done`. `rst_n` low mid-run → all outputs return to reset values at that edge.
